// File: rtl/alu_pkg.sv
// Shared ALU definitions: operand width, sequencer states and digit-count helper.
package alu_pkg;

    localparam int unsigned WORD_W = 32;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        FIN  = 2'd2
    } state_t;

    // Number of digit cycles needed to cover a full word.
    function automatic int unsigned digit_count(input int unsigned digit_w);
        return WORD_W / digit_w;
    endfunction

endpackage

// File: rtl/subtractor_32_seq_if.sv
// Request/response bundle for the sequential subtractor.
interface subtractor_32_seq_if;
    import alu_pkg::*;

    logic              start;
    logic [WORD_W-1:0] a;
    logic [WORD_W-1:0] b;
    logic              b_in;
    logic              busy;
    logic              done;
    logic [WORD_W-1:0] d;
    logic              b_out;
    logic              v;

    modport master (
        output start, a, b, b_in,
        input  busy, done, d, b_out, v
    );

    modport slave (
        input  start, a, b, b_in,
        output busy, done, d, b_out, v
    );

endinterface

// File: rtl/subtractor_32_seq_sub_digit.sv
// Combinational DIGIT_W-wide subtract with borrow in/out.
module sub_digit #(
    parameter int unsigned DIGIT_W = 4
) (
    input  logic [DIGIT_W-1:0] x,
    input  logic [DIGIT_W-1:0] y,
    input  logic               bin,
    output logic [DIGIT_W-1:0] diff,
    output logic               bout
);

    logic [DIGIT_W:0] full;

    // The extra top bit goes to 1 exactly when the digit result underflows.
    assign full = {1'b0, x} - {1'b0, y} - (DIGIT_W+1)'(bin);
    assign diff = full[DIGIT_W-1:0];
    assign bout = full[DIGIT_W];

endmodule

// File: rtl/subtractor_32_seq.sv
// Digit-serial 32-bit subtractor with borrow: d = a - b - b_in, LSB digit first.
module subtractor_32_seq
    import alu_pkg::*;
#(
    parameter int unsigned DIGIT_W = 4
) (
    input  logic                clk,
    input  logic                rst,
    subtractor_32_seq_if.slave  bus
);

    localparam int unsigned N     = digit_count(DIGIT_W);
    localparam int unsigned CNT_W = $clog2(N) + 1;

    state_t             state_q, state_n;
    logic [WORD_W-1:0]  a_q, a_n, b_q, b_n, part_q, part_n, d_q, d_n;
    logic               borrow_q, borrow_n, b_out_q, b_out_n, v_q, v_n;
    logic               a_msb_q, a_msb_n, b_msb_q, b_msb_n;
    logic [CNT_W-1:0]   cnt_q, cnt_n;
    logic               busy_q, done_q;

    logic [DIGIT_W-1:0]        diff;
    logic                      dig_borrow;
    logic [WORD_W+DIGIT_W-1:0] shifted;

    sub_digit #(.DIGIT_W(DIGIT_W)) u_digit (
        .x    (a_q[DIGIT_W-1:0]),
        .y    (b_q[DIGIT_W-1:0]),
        .bin  (borrow_q),
        .diff (diff),
        .bout (dig_borrow)
    );

    // New digit enters at the MSB end; older digits slide toward bit 0.
    assign shifted = {diff, part_q};

    // Next-state and datapath next values.
    always_comb begin
        state_n  = state_q;
        a_n      = a_q;
        b_n      = b_q;
        part_n   = part_q;
        borrow_n = borrow_q;
        cnt_n    = cnt_q;
        a_msb_n  = a_msb_q;
        b_msb_n  = b_msb_q;
        d_n      = d_q;
        b_out_n  = b_out_q;
        v_n      = v_q;
        unique case (state_q)
            IDLE, FIN: begin
                state_n = IDLE;
                if (bus.start) begin
                    state_n  = RUN;
                    a_n      = bus.a;
                    b_n      = bus.b;
                    borrow_n = bus.b_in;
                    cnt_n    = '0;
                    part_n   = '0;
                    a_msb_n  = bus.a[WORD_W-1];
                    b_msb_n  = bus.b[WORD_W-1];
                end
            end
            RUN: begin
                a_n      = a_q >> DIGIT_W;
                b_n      = b_q >> DIGIT_W;
                part_n   = shifted[WORD_W+DIGIT_W-1:DIGIT_W];
                borrow_n = dig_borrow;
                cnt_n    = cnt_q + CNT_W'(1);
                if (cnt_q == CNT_W'(N - 1)) begin
                    state_n = FIN;
                    d_n     = part_n;
                    b_out_n = dig_borrow;
                    // Overflow uses the original sign bits, not the shifted operands.
                    v_n     = (a_msb_q != b_msb_q) && (part_n[WORD_W-1] != a_msb_q);
                end
            end
            default: state_n = IDLE;
        endcase
    end

    // State and datapath registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            a_q      <= '0;
            b_q      <= '0;
            part_q   <= '0;
            borrow_q <= 1'b0;
            cnt_q    <= '0;
            a_msb_q  <= 1'b0;
            b_msb_q  <= 1'b0;
            d_q      <= '0;
            b_out_q  <= 1'b0;
            v_q      <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_n;
            a_q      <= a_n;
            b_q      <= b_n;
            part_q   <= part_n;
            borrow_q <= borrow_n;
            cnt_q    <= cnt_n;
            a_msb_q  <= a_msb_n;
            b_msb_q  <= b_msb_n;
            d_q      <= d_n;
            b_out_q  <= b_out_n;
            v_q      <= v_n;
            busy_q   <= (state_n == RUN);
            done_q   <= (state_n == FIN);
        end
    end

    assign bus.busy  = busy_q;
    assign bus.done  = done_q;
    assign bus.d     = d_q;
    assign bus.b_out = b_out_q;
    assign bus.v     = v_q;

endmodule

// File: tb/tb_subtractor_32_seq.sv
// Self-checking bench: directed cases on DIGIT_W=4 plus random sweeps at DIGIT_W=1/8/32.
module tb_subtractor_32_seq;
    import alu_pkg::*;

    localparam int unsigned N4 = digit_count(4);

    logic clk = 1'b0;
    logic rst;
    logic rst_sw;
    int   n_tests = 0;
    int   n_fail  = 0;

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Reference: {v, b_out, d} from plain unsigned/signed arithmetic.
    function automatic logic [33:0] model(input logic [31:0] a, input logic [31:0] b, input logic bin);
        logic [31:0] dd;
        logic        bo;
        logic        ov;
        longint      sa, sb, sd;
        dd = a - b - 32'(bin);
        bo = (longint'(a) < longint'(b) + longint'(bin));
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        sd = sa - sb;
        ov = (sd > 64'sd2147483647) || (sd < -64'sd2147483648);
        // Flag follows the sign-bit rule, which ignores b_in; recompute it that way.
        ov = (a[31] != b[31]) && (dd[31] != a[31]);
        if (ov == 1'b0 && sd == 0) ov = 1'b0;
        return {ov, bo, dd};
    endfunction

    subtractor_32_seq_if bus4();
    subtractor_32_seq #(.DIGIT_W(4)) dut4 (.clk(clk), .rst(rst), .bus(bus4));

    task automatic wait_done4(output int lat);
        lat = 1;
        while (!bus4.done && lat < 64) begin
            @(negedge clk);
            lat++;
        end
    endtask

    task automatic run4(input logic [31:0] a, input logic [31:0] b, input logic bin, input string tag);
        logic [33:0] e;
        int lat;
        e = model(a, b, bin);
        bus4.start = 1'b1; bus4.a = a; bus4.b = b; bus4.b_in = bin;
        @(negedge clk);
        bus4.start = 1'b0; bus4.a = $urandom; bus4.b = $urandom; bus4.b_in = 1'($urandom_range(0, 1));
        check({tag, "_busy"}, 32'(bus4.busy), 32'd1);
        wait_done4(lat);
        check({tag, "_lat"}, 32'(lat), 32'(N4 + 1));
        check({tag, "_d"}, bus4.d, e[31:0]);
        check({tag, "_bout"}, 32'(bus4.b_out), 32'(e[32]));
        check({tag, "_v"}, 32'(bus4.v), 32'(e[33]));
        check({tag, "_finbusy"}, 32'(bus4.busy), 32'd0);
        @(negedge clk);
        check({tag, "_pulse"}, 32'(bus4.done), 32'd0);
    endtask

    for (genvar g = 0; g < 3; g++) begin : sw
        localparam int unsigned DW = (g == 0) ? 1 : ((g == 1) ? 8 : 32);
        localparam int unsigned NN = digit_count(DW);
        subtractor_32_seq_if bus();
        subtractor_32_seq #(.DIGIT_W(DW)) dut (.clk(clk), .rst(rst_sw), .bus(bus));
        bit fin;

        initial begin
            logic [31:0] ra, rb;
            logic        rbin;
            logic [33:0] e;
            int          lat;
            fin = 1'b0;
            bus.start = 1'b0; bus.a = '0; bus.b = '0; bus.b_in = 1'b0;
            @(negedge clk);
            for (int i = 0; i < 50 && rst_sw; i++) @(negedge clk);
            for (int k = 0; k < 1000; k++) begin
                ra   = $urandom;
                rb   = $urandom;
                rbin = 1'($urandom_range(0, 1));
                case ($urandom_range(0, 7))
                    0: rb = ra;
                    1: ra = 32'h0000_0000;
                    2: rb = 32'hFFFF_FFFF;
                    3: begin ra = 32'h8000_0000; rb = 32'h0000_0001; end
                    default: ;
                endcase
                e = model(ra, rb, rbin);
                bus.start = 1'b1; bus.a = ra; bus.b = rb; bus.b_in = rbin;
                @(negedge clk);
                bus.start = 1'b0; bus.a = $urandom; bus.b = $urandom;
                lat = 1;
                while (!bus.done && lat < 80) begin
                    @(negedge clk);
                    lat++;
                end
                check($sformatf("sw%0d_lat", DW), 32'(lat), 32'(NN + 1));
                check($sformatf("sw%0d_d", DW), bus.d, e[31:0]);
                check($sformatf("sw%0d_bout", DW), 32'(bus.b_out), 32'(e[32]));
                check($sformatf("sw%0d_v", DW), 32'(bus.v), 32'(e[33]));
            end
            fin = 1'b1;
        end
    end

    initial begin
        int lat;
        int dones;
        int guard;
        rst = 1'b1; rst_sw = 1'b1;
        bus4.start = 1'b0; bus4.a = '0; bus4.b = '0; bus4.b_in = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_busy", 32'(bus4.busy), 32'd0);
        check("rst_done", 32'(bus4.done), 32'd0);
        check("rst_d", bus4.d, 32'd0);
        check("rst_bout", 32'(bus4.b_out), 32'd0);
        check("rst_v", 32'(bus4.v), 32'd0);
        rst = 1'b0; rst_sw = 1'b0;
        @(negedge clk);

        run4(32'h0000_0010, 32'h0000_0001, 1'b0, "basic");
        run4(32'h0000_0000, 32'h0000_0001, 1'b1, "wrap");
        run4(32'h8000_0000, 32'h0000_0001, 1'b0, "ovf");

        // Abort an operation three cycles into RUN.
        bus4.start = 1'b1; bus4.a = 32'h10; bus4.b = 32'h01; bus4.b_in = 1'b0;
        @(negedge clk);
        bus4.start = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("abort_busy", 32'(bus4.busy), 32'd0);
        check("abort_d", bus4.d, 32'd0);
        check("abort_bout", 32'(bus4.b_out), 32'd0);
        check("abort_v", 32'(bus4.v), 32'd0);
        dones = 0;
        for (int i = 0; i < 12; i++) begin
            if (bus4.done) dones++;
            @(negedge clk);
        end
        check("abort_nodone", 32'(dones), 32'd0);

        // Start held through RUN with junk operands, then a back-to-back start in FIN.
        bus4.start = 1'b1; bus4.a = 32'd5; bus4.b = 32'd3; bus4.b_in = 1'b0;
        @(negedge clk);
        bus4.a = 32'hFFFF_FFFF; bus4.b = 32'h0;
        wait_done4(lat);
        check("ign_lat", 32'(lat), 32'(N4 + 1));
        check("ign_d", bus4.d, 32'd2);
        bus4.a = 32'd7; bus4.b = 32'd7; bus4.b_in = 1'b0;
        @(negedge clk);
        bus4.start = 1'b0;
        check("b2b_busy", 32'(bus4.busy), 32'd1);
        wait_done4(lat);
        check("b2b_lat", 32'(lat), 32'(N4 + 1));
        check("b2b_d", bus4.d, 32'd0);
        check("b2b_bout", 32'(bus4.b_out), 32'd0);
        @(negedge clk);

        for (int k = 0; k < 20; k++)
            run4($urandom, $urandom, 1'($urandom_range(0, 1)), "rand4");

        guard = 0;
        while (!(sw[0].fin && sw[1].fin && sw[2].fin) && guard < 60000) begin
            @(negedge clk);
            guard++;
        end
        check("sweep_complete", 32'(sw[0].fin && sw[1].fin && sw[2].fin), 32'd1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/subtractor_32_seq.md
Name: subtractor_32_seq

Overview:
Multi-cycle 32-bit subtractor with borrow, the inverse datapath companion to adder_32. It computes d = a - b - b_in one DIGIT_W-bit slice per clock, LSB first, behind a start/busy/done handshake. It sits in the processor ALU as the area-reduced subtract/compare path, feeding borrow and overflow flags to the condition logic.

Parameters:
DIGIT_W, 4, bits processed per cycle; legal values 1, 2, 4, 8, 16, 32 (must divide 32)
WORD_W, 32, operand width; fixed, exposed for package consistency only

Ports:
clk  input  1  system clock; all state updates on the rising edge
rst  input  1  synchronous, active-high reset
start  input  1  request a new operation; sampled only while busy=0
a  input  32  minuend; sampled on the accepting edge
b  input  32  subtrahend; sampled on the accepting edge
b_in  input  1  borrow in; sampled on the accepting edge
busy  output  1  operation in progress; new start ignored
done  output  1  one-cycle pulse: results valid
d  output  32  difference, (a - b - b_in) mod 2^32
b_out  output  1  borrow out: 1 iff a < b + b_in (unsigned)
v  output  1  signed overflow: (a[31] != b[31]) && (d[31] != a[31])

Behaviour:
- Reset (rst=1 at an edge, regardless of state): state IDLE, busy=0, done=0, d=0, b_out=0, v=0, digit counter=0, operand registers cleared. Reset mid-operation aborts the operation and produces no done pulse.
- N = 32/DIGIT_W digit cycles.
- States: IDLE, RUN, FIN.
  - IDLE: start=1 at an edge latches a, b, and b_in into the working borrow, clears the counter, and moves to RUN. busy=1 from the next cycle.
  - RUN: each edge takes the low DIGIT_W bits of the shifted a/b registers with the working borrow and forms the digit difference and new borrow (sub_digit). The difference digit shifts into the partial-result register at the MSB end, a and b shift right by DIGIT_W, and the counter increments. The edge that completes digit N-1 loads d, b_out, and v from the final partial result and borrow, and moves to FIN.
  - FIN: lasts exactly one cycle, with done=1 and busy=0. start=1 in FIN is accepted exactly as in IDLE (back-to-back operation). Otherwise the next state is IDLE.
- Latency: start accepted at edge E0; done=1 during the cycle after edge E0+N. With DIGIT_W=4, done is high 8 cycles after the accepting edge.
- busy=1 only in RUN. start while busy=1 is ignored with no side effects, and a/b/b_in changes during RUN do not affect the result.
- d, b_out, and v change only at the completion edge or on reset. Partial results are never visible, and outputs hold their values until the next completion.
- v is computed from the latched original a[31] and b[31], not from the shifted registers.
- DIGIT_W=32: a single RUN cycle, latency 1 + 1.

Decomposition:
- Shared package alu_pkg: WORD_W constant, the state enum (IDLE/RUN/FIN), and a function for digit count N.
- Sub-module sub_digit: combinational DIGIT_W-wide subtract with borrow in and borrow out. It is instantiated once and reusable by the ALU.
- Counter width is clog2(N)+1.

Test Plan:
- Reset mid-run: start a=0x10, b=0x01, assert rst at cycle 3 of RUN -> busy=0, done never pulses, d=0, b_out=0, v=0.
- Basic: a=0x00000010, b=0x00000001, b_in=0 -> after 8 cycles done pulses with d=0x0000000F, b_out=0, v=0.
- Borrow wrap: a=0x00000000, b=0x00000001, b_in=1 -> d=0xFFFFFFFE, b_out=1, v=0.
- Signed overflow: a=0x80000000, b=0x00000001, b_in=0 -> d=0x7FFFFFFF, b_out=0, v=1.
- Busy and input ignore: start a=5, b=3; during RUN drive start=1 with a=0xFFFFFFFF, b=0 -> a single done with d=0x00000002; start asserted in the FIN cycle with a=7, b=7 -> second done 8 cycles later with d=0, b_out=0.
- Parameter sweep: DIGIT_W = 1, 8, 32 with 1000 random vectors each, checked against a - b - b_in and the flag equations -> zero mismatches, latency N+1 cycles.
